// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that hands one shared memory unit to
// NUM_PORTS requesters, issues a one-cycle execute strobe, waits for the
// result (with an optional watchdog) and returns a per-port completion pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no operation in flight; grant when powered, memory ready, request
// ISSUE  | mem_execute high for this single cycle
// WAIT   | waiting for mem_ready; first cycle ignored (memory still idle)
// DONE   | req_done[grant_id] (and req_err on timeout) high; pointer advances
module mem_port_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           power,
   input  logic [NUM_PORTS-1:0]           req_execute,
   input  logic [2*NUM_PORTS-1:0]         req_func,
   input  logic [ADDR_W*NUM_PORTS-1:0]    req_addr0,
   input  logic [ADDR_W*NUM_PORTS-1:0]    req_addr1,
   input  logic [4*NUM_PORTS-1:0]         req_type_info,
   output logic [NUM_PORTS-1:0]           req_done,
   output logic [NUM_PORTS-1:0]           req_err,
   output logic [ADDR_W-1:0]              resp_addr,
   output logic [DATA_W-1:0]              resp_data,
   output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
   output logic                           busy,
   output logic [1:0]                     mem_func,
   output logic [ADDR_W-1:0]              mem_addr0,
   output logic [ADDR_W-1:0]              mem_addr1,
   output logic [3:0]                     mem_type_info,
   output logic                           mem_execute,
   input  logic [ADDR_W-1:0]              mem_addr_out,
   input  logic [DATA_W-1:0]              mem_data_out,
   input  logic                           mem_ready
);

   localparam int GID_W = $clog2(NUM_PORTS);
   // Counter only needs to reach TIMEOUT-1; it saturates when the watchdog is off.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [GID_W-1:0] GID_LAST = GID_W'(NUM_PORTS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t              state_q;
   logic [GID_W-1:0]    ptr_q;
   logic [GID_W-1:0]    grant_id_q;
   logic [CNT_W-1:0]    wait_cnt_q;
   logic                mem_execute_q;
   logic [1:0]          mem_func_q;
   logic [ADDR_W-1:0]   mem_addr0_q;
   logic [ADDR_W-1:0]   mem_addr1_q;
   logic [3:0]          mem_type_info_q;
   logic [ADDR_W-1:0]   resp_addr_q;
   logic [DATA_W-1:0]   resp_data_q;
   logic [NUM_PORTS-1:0] req_done_q;
   logic [NUM_PORTS-1:0] req_err_q;

   logic                any_req;
   logic [GID_W-1:0]    sel;

   function automatic logic [GID_W-1:0] rr_idx(input logic [GID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_PORTS) s = s - NUM_PORTS;
      return GID_W'(s);
   endfunction

   // Round-robin pick: scan downward so the port closest to ptr wins.
   always_comb begin
      sel     = ptr_q;
      any_req = 1'b0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req_execute[rr_idx(ptr_q, i)]) begin
            sel     = rr_idx(ptr_q, i);
            any_req = 1'b1;
         end
      end
   end

   // Sequencing FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         ptr_q           <= '0;
         grant_id_q      <= '0;
         wait_cnt_q      <= '0;
         mem_execute_q   <= 1'b0;
         mem_func_q      <= '0;
         mem_addr0_q     <= '0;
         mem_addr1_q     <= '0;
         mem_type_info_q <= '0;
         resp_addr_q     <= '0;
         resp_data_q     <= '0;
         req_done_q      <= '0;
         req_err_q       <= '0;
      end else begin
         mem_execute_q <= 1'b0;
         req_done_q    <= '0;
         req_err_q     <= '0;
         case (state_q)
            S_IDLE: begin
               if (power && mem_ready && any_req) begin
                  grant_id_q      <= sel;
                  mem_func_q      <= req_func[2*int'(sel) +: 2];
                  mem_addr0_q     <= req_addr0[ADDR_W*int'(sel) +: ADDR_W];
                  mem_addr1_q     <= req_addr1[ADDR_W*int'(sel) +: ADDR_W];
                  mem_type_info_q <= req_type_info[4*int'(sel) +: 4];
                  mem_execute_q   <= 1'b1;
                  state_q         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt_q <= '0;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt_q != '0 && mem_ready) begin
                  resp_addr_q            <= mem_addr_out;
                  resp_data_q            <= mem_data_out;
                  req_done_q[grant_id_q] <= 1'b1;
                  state_q                <= S_DONE;
               end else if (TIMEOUT > 0 && wait_cnt_q == CNT_LAST) begin
                  resp_data_q            <= '0;
                  req_done_q[grant_id_q] <= 1'b1;
                  req_err_q[grant_id_q]  <= 1'b1;
                  state_q                <= S_DONE;
               end else if (wait_cnt_q != CNT_MAX) begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               ptr_q   <= (grant_id_q == GID_LAST) ? '0 : grant_id_q + 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign grant_id      = grant_id_q;
   assign mem_execute   = mem_execute_q;
   assign mem_func      = mem_func_q;
   assign mem_addr0     = mem_addr0_q;
   assign mem_addr1     = mem_addr1_q;
   assign mem_type_info = mem_type_info_q;
   assign resp_addr     = resp_addr_q;
   assign resp_data     = resp_data_q;
   assign req_done      = req_done_q;
   assign req_err       = req_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory unit plus a transaction-level
// round-robin model; each scenario task checks its own results.
module tb_mem_port_arbiter;
   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst, power;
   logic [N-1:0]    req_execute;
   logic [2*N-1:0]  req_func;
   logic [AW*N-1:0] req_addr0, req_addr1;
   logic [4*N-1:0]  req_type_info;
   logic [N-1:0]    req_done, req_err;
   logic [AW-1:0]   resp_addr;
   logic [DW-1:0]   resp_data;
   logic [1:0]      grant_id;
   logic            busy;
   logic [1:0]      mem_func;
   logic [AW-1:0]   mem_addr0, mem_addr1;
   logic [3:0]      mem_type_info;
   logic            mem_execute;
   logic [AW-1:0]   mem_addr_out;
   logic [DW-1:0]   mem_data_out;
   logic            mem_ready;

   int checks = 0;
   int errors = 0;
   int exp_ptr = 0;

   logic [1:0]  op_f[N];
   logic [15:0] op_a0[N], op_a1[N];
   logic [3:0]  op_t[N];

   int          mem_lat = 0;
   bit          mem_hang = 1'b0;
   logic [15:0] mem_val_addr = '0;
   logic [31:0] mem_val_data = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .power(power),
      .req_execute(req_execute), .req_func(req_func),
      .req_addr0(req_addr0), .req_addr1(req_addr1), .req_type_info(req_type_info),
      .req_done(req_done), .req_err(req_err),
      .resp_addr(resp_addr), .resp_data(resp_data),
      .grant_id(grant_id), .busy(busy),
      .mem_func(mem_func), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
      .mem_type_info(mem_type_info), .mem_execute(mem_execute),
      .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
   );

   // Memory unit: idle-ready; drops ready the cycle after execute, stays low
   // mem_lat+1 cycles (forever when hung), returns to ready if the arbiter goes idle.
   initial begin
      mem_ready = 1'b1; mem_addr_out = '0; mem_data_out = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_execute === 1'b1) begin
            @(posedge clk); #1;
            for (int c = 0; c < 300; c++) begin
               if (!mem_hang && c > mem_lat) break;
               mem_ready = 1'b0;
               mem_data_out = $urandom;
               mem_addr_out = 16'($urandom);
               @(posedge clk); #1;
               if (busy !== 1'b1) break;
            end
            mem_ready = 1'b1;
            mem_data_out = mem_val_data;
            mem_addr_out = mem_val_addr;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int rr_pick(input int ptr, input logic [N-1:0] m);
      for (int i = 0; i < N; i++) begin
         int p;
         p = (ptr + i) % N;
         if (m[p]) return p;
      end
      return -1;
   endfunction

   task automatic apply_ops();
      for (int p = 0; p < N; p++) begin
         req_func[2*p +: 2]      = op_f[p];
         req_addr0[AW*p +: AW]   = op_a0[p];
         req_addr1[AW*p +: AW]   = op_a1[p];
         req_type_info[4*p +: 4] = op_t[p];
      end
   endtask

   task automatic randomize_ops();
      for (int p = 0; p < N; p++) begin
         op_f[p]  = 2'($urandom);
         op_a0[p] = 16'($urandom);
         op_a1[p] = 16'($urandom);
         op_t[p]  = 4'($urandom);
      end
      apply_ops();
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Observes one operation from the current cycle until a req_done pulse.
   task automatic wait_done(input int budget, input bit scramble, input bit drop_at_issue,
                            output bit got, output int cyc, output logic [N-1:0] dv,
                            output logic [N-1:0] ev, output int nex);
      got = 1'b0; cyc = 0; nex = 0; dv = '0; ev = '0;
      while (!got && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (mem_execute === 1'b1) begin
            nex++;
            if (drop_at_issue) begin req_execute = '0; power = 1'b0; end
         end
         if (scramble && busy === 1'b1) randomize_ops();
         if (req_done !== '0) begin got = 1'b1; dv = req_done; ev = req_err; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; power = 1'b1; req_execute = '1;
      randomize_ops();
      idle(3);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (mem_execute !== 1'b0) begin errors++; $display("FAIL reset_exec: got %0b want 0", mem_execute); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
      checks++; if (req_done !== '0 || req_err !== '0) begin errors++; $display("FAIL reset_done_err: got %b/%b want 0/0", req_done, req_err); end
      checks++; if (resp_data !== '0 || resp_addr !== '0) begin errors++; $display("FAIL reset_resp: got %h/%h want 0/0", resp_addr, resp_data); end
      checks++; if ({mem_func, mem_addr0, mem_addr1, mem_type_info} !== '0) begin errors++; $display("FAIL reset_mem_ops: got %h/%h/%h/%h want 0", mem_func, mem_addr0, mem_addr1, mem_type_info); end
      req_execute = '0;
      rst = 1'b0;
      exp_ptr = 0;
      idle(1);
   endtask

   task automatic test_contention();
      bit got; int cyc, nex, g, lat; logic [N-1:0] dv, ev, ex;
      req_execute = 3'b011;
      for (int op = 0; op < 4; op++) begin
         lat = $urandom_range(0, 3);
         mem_lat = lat;
         mem_val_data = $urandom; mem_val_addr = 16'($urandom);
         g = rr_pick(exp_ptr, 3'b011);
         ex = '0; ex[g] = 1'b1;
         wait_done(40, 1'b0, 1'b0, got, cyc, dv, ev, nex);
         checks++; if (!got) begin errors++; $display("FAIL contention_timeout: op %0d no req_done", op); end
         checks++; if (dv !== ex) begin errors++; $display("FAIL contention_order: op %0d got %b want %b", op, dv, ex); end
         checks++; if (nex !== 1) begin errors++; $display("FAIL contention_exec: op %0d got %0d execs want 1", op, nex); end
         checks++; if (cyc !== lat + 4 + (op > 0 ? 1 : 0)) begin errors++; $display("FAIL contention_lat: op %0d got %0d want %0d", op, cyc, lat + 4 + (op > 0 ? 1 : 0)); end
         checks++; if (resp_data !== mem_val_data || ev !== '0) begin errors++; $display("FAIL contention_resp: op %0d got %h err %b want %h err 0", op, resp_data, ev, mem_val_data); end
         exp_ptr = (g + 1) % N;
      end
      req_execute = '0;
      idle(2);
   endtask

   task automatic test_single();
      bit got; int cyc, nex; logic [N-1:0] dv, ev; logic [15:0] a1; logic [3:0] t;
      randomize_ops();
      op_f[0] = 2'd2; op_a0[0] = 16'h0010; a1 = op_a1[0]; t = op_t[0];
      apply_ops();
      mem_lat = 0; mem_val_data = 32'hDEADBEEF; mem_val_addr = 16'($urandom);
      req_execute = 3'b001;
      wait_done(20, 1'b1, 1'b0, got, cyc, dv, ev, nex);
      req_execute = '0;
      checks++; if (!got) begin errors++; $display("FAIL single_timeout: no req_done"); end
      checks++; if (cyc !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", cyc); end
      checks++; if (dv !== 3'b001 || ev !== 3'b000) begin errors++; $display("FAIL single_done: got %b err %b want 001 err 000", dv, ev); end
      checks++; if (nex !== 1) begin errors++; $display("FAIL single_exec: got %0d want 1", nex); end
      checks++; if (resp_data !== 32'hDEADBEEF || resp_addr !== mem_val_addr) begin errors++; $display("FAIL single_resp: got %h/%h want %h/deadbeef", resp_addr, resp_data, mem_val_addr); end
      checks++; if (mem_func !== 2'd2 || mem_addr0 !== 16'h0010 || mem_addr1 !== a1 || mem_type_info !== t) begin errors++; $display("FAIL single_ops: got %h/%h/%h/%h want 2/0010/%h/%h", mem_func, mem_addr0, mem_addr1, mem_type_info, a1, t); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d want 0", grant_id); end
      exp_ptr = 1;
      idle(1);
      checks++; if (req_done !== '0) begin errors++; $display("FAIL single_pulse_width: got %b want 000", req_done); end
   endtask

   task automatic test_back_to_back();
      bit got; int cyc, nex, g; logic [N-1:0] dv, ev, ex, m;
      mem_lat = 0;
      m = 3'b001;
      req_execute = m;
      for (int op = 0; op < 3; op++) begin
         mem_val_data = $urandom;
         g = rr_pick(exp_ptr, m);
         ex = '0; ex[g] = 1'b1;
         wait_done(30, 1'b0, 1'b0, got, cyc, dv, ev, nex);
         checks++; if (!got || dv !== ex) begin errors++; $display("FAIL b2b_yield: op %0d got %b want %b", op, dv, ex); end
         exp_ptr = (g + 1) % N;
         m = 3'b101;
         req_execute = m;
      end
      req_execute = '0;
      idle(2);
   endtask

   task automatic test_timeout();
      bit got; int cyc, nex, g; logic [N-1:0] dv, ev, ex, m;
      randomize_ops();
      m = 3'($urandom_range(1, 7));
      g = rr_pick(exp_ptr, m);
      ex = '0; ex[g] = 1'b1;
      mem_hang = 1'b1;
      req_execute = m;
      wait_done(40, 1'b0, 1'b0, got, cyc, dv, ev, nex);
      req_execute = '0;
      mem_hang = 1'b0;
      checks++; if (!got) begin errors++; $display("FAIL timeout_bound: no req_done"); end
      checks++; if (cyc !== TO + 2) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", cyc, TO + 2); end
      checks++; if (dv !== ex || ev !== ex) begin errors++; $display("FAIL timeout_pulse: done %b err %b want %b", dv, ev, ex); end
      checks++; if (resp_data !== '0) begin errors++; $display("FAIL timeout_data: got %h want 0", resp_data); end
      exp_ptr = (g + 1) % N;
      idle(2);
      // Longest successful wait just inside the watchdog.
      m = 3'b100; g = rr_pick(exp_ptr, m);
      ex = '0; ex[g] = 1'b1;
      mem_lat = TO - 3; mem_val_data = $urandom;
      req_execute = m;
      wait_done(40, 1'b0, 1'b0, got, cyc, dv, ev, nex);
      req_execute = '0;
      checks++; if (!got || cyc !== TO + 1 || dv !== ex || ev !== '0) begin errors++; $display("FAIL timeout_edge_ok: got %0d cyc done %b err %b want %0d cyc %b err 000", cyc, dv, ev, TO + 1, ex); end
      checks++; if (resp_data !== mem_val_data) begin errors++; $display("FAIL timeout_edge_data: got %h want %h", resp_data, mem_val_data); end
      exp_ptr = (g + 1) % N;
      idle(2);
   endtask

   task automatic test_power();
      bit got; int cyc, nex, busy_cnt; logic [N-1:0] dv, ev;
      mem_lat = 0;
      power = 1'b0;
      req_execute = 3'b010;
      nex = 0; busy_cnt = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (mem_execute === 1'b1) nex++;
         if (busy !== 1'b0) busy_cnt++;
      end
      checks++; if (nex !== 0 || busy_cnt !== 0) begin errors++; $display("FAIL power_block: got %0d execs %0d busy want 0/0", nex, busy_cnt); end
      power = 1'b1;
      wait_done(20, 1'b0, 1'b0, got, cyc, dv, ev, nex);
      req_execute = '0;
      checks++; if (!got || cyc !== 4 || dv !== 3'b010) begin errors++; $display("FAIL power_grant: got %0d cyc done %b want 4 cyc 010", cyc, dv); end
      exp_ptr = 2;
      idle(2);
   endtask

   task automatic test_early_drop();
      bit got; int cyc, nex; logic [N-1:0] dv, ev;
      mem_lat = 1; mem_val_data = $urandom;
      req_execute = 3'b010;
      wait_done(20, 1'b0, 1'b1, got, cyc, dv, ev, nex);
      power = 1'b1;
      checks++; if (!got || dv !== 3'b010) begin errors++; $display("FAIL early_drop_done: got %b want 010", dv); end
      checks++; if (nex !== 1 || cyc !== 5) begin errors++; $display("FAIL early_drop_flow: got %0d execs %0d cyc want 1/5", nex, cyc); end
      checks++; if (resp_data !== mem_val_data) begin errors++; $display("FAIL early_drop_data: got %h want %h", resp_data, mem_val_data); end
      exp_ptr = 2;
      idle(2);
   endtask

   task automatic test_reset_mid();
      bit got; int cyc, nex, dcnt; logic [N-1:0] dv, ev;
      mem_hang = 1'b1;
      req_execute = 3'b100;
      idle(1);
      req_execute = '0;
      idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      mem_hang = 1'b0;
      checks++; if (busy !== 1'b0 || mem_execute !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy %0b exec %0b want 0/0", busy, mem_execute); end
      checks++; if (grant_id !== 2'd0 || mem_addr0 !== '0) begin errors++; $display("FAIL rstmid_regs: grant %0d addr0 %h want 0/0", grant_id, mem_addr0); end
      dcnt = 0;
      if (req_done !== '0) dcnt++;
      repeat (12) begin @(posedge clk); #1; if (req_done !== '0) dcnt++; end
      checks++; if (dcnt !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dcnt); end
      exp_ptr = 0;
      mem_lat = 0;
      req_execute = 3'b111;
      wait_done(20, 1'b0, 1'b0, got, cyc, dv, ev, nex);
      req_execute = '0;
      checks++; if (!got || dv !== 3'b001) begin errors++; $display("FAIL rstmid_ptr: got %b want 001", dv); end
      exp_ptr = 1;
      idle(2);
   endtask

   task automatic test_random();
      bit got; int cyc, nex, g, lat; logic [N-1:0] dv, ev, ex, m;
      logic [1:0] ef; logic [15:0] ea0, ea1; logic [3:0] et;
      for (int it = 0; it < 24; it++) begin
         randomize_ops();
         m = 3'($urandom_range(1, 7));
         g = rr_pick(exp_ptr, m);
         ex = '0; ex[g] = 1'b1;
         ef = op_f[g]; ea0 = op_a0[g]; ea1 = op_a1[g]; et = op_t[g];
         lat = $urandom_range(0, 4);
         mem_lat = lat; mem_val_data = $urandom; mem_val_addr = 16'($urandom);
         req_execute = m;
         wait_done(30, 1'b1, 1'b0, got, cyc, dv, ev, nex);
         req_execute = '0;
         checks++; if (!got || dv !== ex || ev !== '0) begin errors++; $display("FAIL rand_done: it %0d got %b err %b want %b err 000", it, dv, ev, ex); end
         checks++; if (cyc !== lat + 4 || nex !== 1) begin errors++; $display("FAIL rand_timing: it %0d got %0d cyc %0d execs want %0d/1", it, cyc, nex, lat + 4); end
         checks++; if (grant_id !== 2'(g)) begin errors++; $display("FAIL rand_grant: it %0d got %0d want %0d", it, grant_id, g); end
         checks++; if (mem_func !== ef || mem_addr0 !== ea0 || mem_addr1 !== ea1 || mem_type_info !== et) begin errors++; $display("FAIL rand_ops: it %0d got %h/%h/%h/%h want %h/%h/%h/%h", it, mem_func, mem_addr0, mem_addr1, mem_type_info, ef, ea0, ea1, et); end
         checks++; if (resp_data !== mem_val_data || resp_addr !== mem_val_addr) begin errors++; $display("FAIL rand_resp: it %0d got %h/%h want %h/%h", it, resp_addr, resp_data, mem_val_addr, mem_val_data); end
         exp_ptr = (g + 1) % N;
         idle($urandom_range(1, 3));
      end
   endtask

   initial begin
      rst = 1'b1; power = 1'b1; req_execute = '0;
      req_func = '0; req_addr0 = '0; req_addr1 = '0; req_type_info = '0;
      test_reset();
      test_contention();
      test_single();
      test_back_to_back();
      test_timeout();
      test_power();
      test_early_drop();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
